// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmit core with frame sequencer, LSB-first data
// shift register, bit counter and parity generator. One CLK cycle is one
// bit period. TX_OUT and busy are registered from the next state, so both
// change on the same edge as the state they describe.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  Data_Ack,
    output logic                  TX_OUT,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                  state_r;
    state_t                  next_state_s;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [CNT_WIDTH-1:0]    cnt_r;
    logic                    par_en_r;
    logic                    stop2_r;
    logic                    par_r;
    logic                    tx_out_r;
    logic                    busy_r;
    logic                    accept_window_s;
    logic                    accept_s;
    logic                    tx_next_s;

    // Parity bit for a data word: XOR of all data bits, inverted for odd parity.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

    // Accept window: idle, or the final stop-bit cycle of the current frame.
    always_comb begin
        accept_window_s = 1'b0;
        case (state_r)
            ST_IDLE:  accept_window_s = 1'b1;
            ST_STOP1: accept_window_s = ~stop2_r;
            ST_STOP2: accept_window_s = 1'b1;
            default:  accept_window_s = 1'b0;
        endcase
    end

    assign accept_s = Data_Valid & accept_window_s;
    assign Data_Ack = accept_s & RST;

    // Next-state logic and the line value that the next state will drive.
    always_comb begin
        next_state_s = ST_IDLE;
        tx_next_s    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: next_state_s = ST_DATA;
            ST_DATA: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = par_en_r ? ST_PARITY : ST_STOP1;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: next_state_s = ST_STOP1;
            ST_STOP1: begin
                if (stop2_r) begin
                    next_state_s = ST_STOP2;
                end else if (accept_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_STOP2: begin
                if (accept_s) begin
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase

        case (next_state_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_r[0];
            ST_PARITY: tx_next_s = par_r;
            ST_STOP1:  tx_next_s = 1'b1;
            ST_STOP2:  tx_next_s = 1'b1;
            ST_IDLE:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // State, registered line outputs, bit counter and per-frame latches.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r  <= ST_IDLE;
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
            shift_r  <= '0;
            cnt_r    <= '0;
            par_en_r <= 1'b0;
            stop2_r  <= 1'b0;
            par_r    <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            tx_out_r <= tx_next_s;
            busy_r   <= (next_state_s != ST_IDLE);

            if (accept_s) begin
                shift_r  <= P_DATA;
                par_en_r <= PAR_EN;
                stop2_r  <= STOP2;
                par_r    <= calc_parity(P_DATA, PAR_TYP);
            end else if (next_state_s == ST_DATA) begin
                // Bit 0 goes to the line at this edge; expose the next bit.
                shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
            end else begin
                shift_r <= shift_r;
            end

            if ((state_r == ST_DATA) && (cnt_r != LAST_CNT)) begin
                cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= '0;
            end
        end
    end

    assign TX_OUT = tx_out_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core: an 8-bit and a 5-bit instance share the clock
// and reset. Expected {TX_OUT, busy} per cycle is pushed to a scoreboard queue
// when a frame is launched and popped/compared one bit period at a time.
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       Data_Ack;
    logic       TX_OUT;
    logic       busy;

    logic [4:0] p_data5;
    logic       dv5;
    logic       pen5;
    logic       ptyp5;
    logic       stop25;
    logic       ack5;
    logic       tx5;
    logic       busy5;

    int         checks;
    int         errors;
    logic [1:0] sb[$];
    logic [1:0] exp_v;

    uart_tx_core #(.DATA_WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
        .Data_Ack(Data_Ack), .TX_OUT(TX_OUT), .busy(busy)
    );

    uart_tx_core #(.DATA_WIDTH(5)) dut5 (
        .CLK(CLK), .RST(RST), .P_DATA(p_data5), .Data_Valid(dv5),
        .PAR_EN(pen5), .PAR_TYP(ptyp5), .STOP2(stop25),
        .Data_Ack(ack5), .TX_OUT(tx5), .busy(busy5)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference frame model: pushes {tx, busy} for every bit period of a frame.
    function automatic void push_frame(input int width, input logic [15:0] data,
                                       input logic pen, input logic ptyp,
                                       input logic stop2);
        int ones;
        ones = 0;
        sb.push_back(2'b01);
        for (int i = 0; i < width; i++) begin
            sb.push_back({data[i], 1'b1});
            if (data[i]) ones++;
        end
        if (pen) sb.push_back({((ones % 2) == 1) ^ ptyp, 1'b1});
        sb.push_back(2'b11);
        if (stop2) sb.push_back(2'b11);
    endfunction

    task automatic test_reset();
        RST = 1'b0;
        Data_Valid = 1'b1;
        dv5 = 1'b1;
        #23;
        checks++;
        if ({TX_OUT, busy, Data_Ack} !== 3'b100) begin
            errors++;
            $display("FAIL reset8 tx/busy/ack=%b required=100", {TX_OUT, busy, Data_Ack});
        end
        checks++;
        if ({tx5, busy5, ack5} !== 3'b100) begin
            errors++;
            $display("FAIL reset5 tx/busy/ack=%b required=100", {tx5, busy5, ack5});
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        dv5 = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_parity();
        int n;
        for (int t = 0; t < 2; t++) begin
            @(negedge CLK);
            P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = t[0]; STOP2 = 1'b0;
            Data_Valid = 1'b1;
            #1;
            checks++;
            if (Data_Ack !== 1'b1) begin
                errors++;
                $display("FAIL parity_ack typ=%0d ack=%b required=1", t, Data_Ack);
            end
            push_frame(8, {8'h00, P_DATA}, 1'b1, t[0], 1'b0);
            sb.push_back(2'b10);
            n = sb.size();
            for (int k = 0; k < n; k++) begin
                @(negedge CLK);
                Data_Valid = 1'b0;
                PAR_TYP = ~PAR_TYP;
                exp_v = sb.pop_front();
                checks++;
                if ({TX_OUT, busy} !== exp_v) begin
                    errors++;
                    $display("FAIL parity typ=%0d k=%0d tx/busy=%b required=%b", t, k, {TX_OUT, busy}, exp_v);
                end
            end
        end
    endtask

    task automatic test_stop2_ignore();
        int n;
        @(negedge CLK);
        P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b1;
        Data_Valid = 1'b1;
        #1;
        checks++;
        if (Data_Ack !== 1'b1) begin
            errors++;
            $display("FAIL stop2_ack ack=%b required=1", Data_Ack);
        end
        push_frame(8, 16'h0000, 1'b0, 1'b0, 1'b1);
        sb.push_back(2'b10);
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            exp_v = sb.pop_front();
            checks++;
            if ({TX_OUT, busy} !== exp_v) begin
                errors++;
                $display("FAIL stop2 k=%0d tx/busy=%b required=%b", k, {TX_OUT, busy}, exp_v);
            end
            // Pulse requests and scramble config during the frame, including STOP1.
            Data_Valid = (k >= 1 && k <= 9) ? k[0] : 1'b0;
            P_DATA = 8'hFF; PAR_EN = 1'b1; STOP2 = 1'b0;
            #1;
            if (k >= 1 && k <= 9 && k[0]) begin
                checks++;
                if (Data_Ack !== 1'b0) begin
                    errors++;
                    $display("FAIL stop2_midack k=%0d ack=%b required=0", k, Data_Ack);
                end
            end
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge CLK);
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        Data_Valid = 1'b1;
        #1;
        checks++;
        if (Data_Ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ack0 ack=%b required=1", Data_Ack);
        end
        push_frame(8, 16'h0055, 1'b0, 1'b0, 1'b0);
        push_frame(8, 16'h000F, 1'b0, 1'b0, 1'b0);
        sb.push_back(2'b10);
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            exp_v = sb.pop_front();
            checks++;
            if ({TX_OUT, busy} !== exp_v) begin
                errors++;
                $display("FAIL b2b k=%0d tx/busy=%b required=%b", k, {TX_OUT, busy}, exp_v);
            end
            P_DATA = 8'h0F;
            Data_Valid = (k <= 9);
            #1;
            checks++;
            if (Data_Ack !== (k == 9)) begin
                errors++;
                $display("FAIL b2b_ack k=%0d ack=%b required=%b", k, Data_Ack, (k == 9));
            end
        end
        Data_Valid = 1'b0;
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge CLK);
        P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        Data_Valid = 1'b1;
        push_frame(8, 16'h003C, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if ({TX_OUT, busy} !== exp_v) begin
                errors++;
                $display("FAIL arst_pre k=%0d tx/busy=%b required=%b", k, {TX_OUT, busy}, exp_v);
            end
        end
        // Data bit 3 is on the line now; pull reset between clock edges.
        sb.delete();
        #1;
        RST = 1'b0;
        Data_Valid = 1'b1;
        #1;
        checks++;
        if ({TX_OUT, busy, Data_Ack} !== 3'b100) begin
            errors++;
            $display("FAIL arst tx/busy/ack=%b required=100", {TX_OUT, busy, Data_Ack});
        end
        @(negedge CLK);
        checks++;
        if ({TX_OUT, busy} !== 2'b10) begin
            errors++;
            $display("FAIL arst_hold tx/busy=%b required=10", {TX_OUT, busy});
        end
        RST = 1'b1;
        #1;
        checks++;
        if (Data_Ack !== 1'b1) begin
            errors++;
            $display("FAIL arst_relack ack=%b required=1", Data_Ack);
        end
        push_frame(8, 16'h003C, 1'b0, 1'b0, 1'b0);
        sb.push_back(2'b10);
        n = sb.size();
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            Data_Valid = 1'b0;
            exp_v = sb.pop_front();
            checks++;
            if ({TX_OUT, busy} !== exp_v) begin
                errors++;
                $display("FAIL arst_post k=%0d tx/busy=%b required=%b", k, {TX_OUT, busy}, exp_v);
            end
        end
    endtask

    task automatic test_width5();
        int n;
        for (int t = 0; t < 2; t++) begin
            @(negedge CLK);
            p_data5 = 5'h1F; pen5 = 1'b1; ptyp5 = t[0]; stop25 = 1'b0;
            dv5 = 1'b1;
            #1;
            checks++;
            if (ack5 !== 1'b1) begin
                errors++;
                $display("FAIL w5_ack typ=%0d ack=%b required=1", t, ack5);
            end
            push_frame(5, {11'h000, p_data5}, 1'b1, t[0], 1'b0);
            sb.push_back(2'b10);
            n = sb.size();
            for (int k = 0; k < n; k++) begin
                @(negedge CLK);
                dv5 = 1'b0;
                exp_v = sb.pop_front();
                checks++;
                if ({tx5, busy5} !== exp_v) begin
                    errors++;
                    $display("FAIL w5 typ=%0d k=%0d tx/busy=%b required=%b", t, k, {tx5, busy5}, exp_v);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        P_DATA = 8'h00; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
        p_data5 = 5'h00; dv5 = 1'b0; pen5 = 1'b0; ptyp5 = 1'b0; stop25 = 1'b0;
        RST = 1'b0;
        test_reset();
        test_parity();
        test_stop2_ignore();
        test_back_to_back();
        test_async_reset();
        test_width5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

Parametrised UART transmit core: frame sequencing FSM, data shift register, bit counter and parity generator in one block. Supports configurable data width, even/odd parity, one or two stop bits, and back-to-back frames with no idle gap. Sits in the TX clock domain, fed by the async FIFO read side. One CLK cycle equals one bit period; the baud-rate divider sits upstream.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 5..16.
- CNT_WIDTH, $clog2(DATA_WIDTH), bit-counter width; derived, not overridden.

- CLK  input  1  TX bit clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel frame data; sampled only on acceptance.
- Data_Valid  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled on acceptance.
- STOP2  input  1  1 = two stop bits, 0 = one; sampled on acceptance.
- Data_Ack  output  1  combinational; high in the cycle Data_Valid is accepted.
- TX_OUT  output  1  registered serial line; idle high.
- busy  output  1  registered; high while a frame is on the line.

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Accept window: state IDLE, or the last stop-bit cycle of the current frame (STOP1 with STOP2 latched 0, or STOP2). Data_Ack = Data_Valid & accept window & RST.
- On acceptance: latch P_DATA into shift register; latch PAR_EN, PAR_TYP, STOP2 into frame config; compute parity = ^P_DATA ^ PAR_TYP; next state START.
- Data_Valid outside the accept window is ignored. No buffering. Upstream holds Data_Valid until Data_Ack.
- START: TX_OUT = 0; next DATA; bit counter cleared.
- DATA: TX_OUT = shift-register bit 0 (LSB first). Shift right each cycle. The counter increments; at count DATA_WIDTH-1, go to PARITY if latched PAR_EN, else STOP1.
- PARITY: TX_OUT = latched parity; next STOP1.
- STOP1: TX_OUT = 1. If latched STOP2, next state is STOP2. Otherwise next is START if accepted, else IDLE.
- STOP2: TX_OUT = 1; next START if accepted, else IDLE.
- IDLE: TX_OUT = 1, busy = 0.
- Config inputs changing mid-frame have no effect on the current frame.
- Illegal state encodings recover to IDLE with TX_OUT = 1.

## Timing
- Reset (async, RST low): state IDLE, TX_OUT = 1, busy = 0, Data_Ack = 0, shift register/counter/config = 0. Takes effect immediately, including mid-frame. The partial frame is abandoned, with no stop-bit completion.
- TX_OUT and busy are registered with the state. Both change at the same edge as the state they reflect.
- Acceptance in cycle N: cycle N+1 TX_OUT = 0 (start) and busy = 1. Data bit i appears in cycle N+2+i.
- Frame length L = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles. busy is high for exactly L cycles per isolated frame.
- Back-to-back: if acceptance occurs in the last stop cycle, the next start bit immediately follows. busy stays high continuously and the line has no idle cycle.
- First cycle after reset release: accept window open (IDLE).

## Test plan
- DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0 -> Data_Ack 1 cycle; TX_OUT from next cycle = 0,1,0,1,0,0,1,0,1,0,1 (parity 0), then 1 idle; busy high exactly 11 cycles.
- Same with PAR_TYP=1 -> parity bit 1; all other bits unchanged.
- P_DATA=0x00, PAR_EN=0, STOP2=1 -> TX_OUT = 0, eight 0s, 1, 1; busy 11 cycles; Data_Valid pulses mid-frame get no Data_Ack and alter nothing.
- Back-to-back: 0x55 then 0x0F (PAR_EN=0, STOP2=0), Data_Valid held -> second Data_Ack in first frame's stop cycle. Required TX_OUT: 0,1,0,1,0,1,0,1,0,1, 0,1,1,1,1,0,0,0,0,1. busy is high for 20 consecutive cycles.
- Reset asserted during data bit 3 -> TX_OUT = 1 and busy = 0 asynchronously. After release, a new 0x3C frame transmits cleanly from its start bit.
- DATA_WIDTH=5, P_DATA=0x1F, PAR_EN=1: PAR_TYP=0 -> parity 1, PAR_TYP=1 -> parity 0. Frame 0,1,1,1,1,1,p,1; busy 8 cycles.
